// File: rtl/block_controller.sv
// block_controller: dino-jump game FSM with block scroller, scoring and VGA pixel colour
module block_controller #(
    parameter int WIN_SCORE = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bright,
    input  logic        up,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    output logic [11:0] rgb,
    output logic [15:0] score,
    output logic        q_I,
    output logic        q_Game,
    output logic        q_Done
);
    typedef enum logic [1:0] {I, GAME, DONE} state_t;
    state_t      state, state_n;
    logic [9:0]  bx, bx_n;
    logic [6:0]  dy, dy_n;
    logic        airborne, airborne_n;
    logic [4:0]  phase, phase_n;
    logic [15:0] score_n;
    logic        collision, dino_on, block_on, ground_on;
    assign collision = (bx <= 10'd231) && (bx + 10'd15 >= 10'd200) && (dy < 7'd32);
    assign q_I    = state == I;
    assign q_Game = state == GAME;
    assign q_Done = state == DONE;
    // state and position registers, cleared asynchronously to the idle start position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= I;
            score    <= '0;
            bx       <= 10'd780;
            dy       <= '0;
            airborne <= 1'b0;
            phase    <= '0;
        end else begin
            state    <= state_n;
            score    <= score_n;
            bx       <= bx_n;
            dy       <= dy_n;
            airborne <= airborne_n;
            phase    <= phase_n;
        end
    end
    // next state: restart from idle/done, otherwise scroll, score and jump unless colliding
    always_comb begin
        state_n    = state;
        score_n    = score;
        bx_n       = bx;
        dy_n       = dy;
        airborne_n = airborne;
        phase_n    = phase;
        case (state)
            I, DONE: begin
                if (up) begin
                    state_n    = GAME;
                    score_n    = '0;
                    bx_n       = 10'd780;
                    dy_n       = '0;
                    airborne_n = 1'b0;
                    phase_n    = '0;
                end
            end
            GAME: begin
                if (collision) begin
                    state_n = DONE;
                end else begin
                    if (bx <= 10'd143) begin
                        bx_n    = 10'd780;
                        score_n = score + 16'd1;
                        if (score + 16'd1 == 16'(WIN_SCORE)) state_n = DONE;
                    end else begin
                        bx_n = bx - 10'd4;
                    end
                    if (airborne) begin
                        dy_n    = phase[4] ? dy - 7'd4 : dy + 7'd4;
                        phase_n = phase + 5'd1;
                        if (phase == 5'd31) airborne_n = 1'b0;
                    end else if (up) begin
                        airborne_n = 1'b1;
                        phase_n    = '0;
                    end
                end
            end
            default: state_n = I;
        endcase
    end
    // pixel colour: dino over block over ground over white sky, black outside visible area
    always_comb begin
        dino_on   = (hCount >= 10'd200) && (hCount <= 10'd231) &&
                    (vCount >= 10'd368 - {3'b0, dy}) && (vCount <= 10'd399 - {3'b0, dy});
        block_on  = (hCount >= bx) && (hCount <= bx + 10'd15) &&
                    (vCount >= 10'd368) && (vCount <= 10'd399);
        ground_on = (vCount >= 10'd400) && (vCount <= 10'd403);
        rgb = !bright  ? 12'h000 :
              dino_on  ? (q_Done ? 12'hF00 : 12'h0A0) :
              block_on ? 12'h000 :
              ground_on ? 12'h888 : 12'hFFF;
    end
endmodule

// File: tb/tb_block_controller.sv
// tb_block_controller: directed checks of block_controller game flow, jump, scoring and colours
module tb_block_controller;
    logic        clk = 1'b0;
    logic        rst, bright, up;
    logic [9:0]  hCount, vCount;
    logic [11:0] rgb;
    logic [15:0] score;
    logic        q_I, q_Game, q_Done;
    int checks = 0;
    int errors = 0;

    block_controller dut (
        .clk(clk), .rst(rst), .bright(bright), .up(up),
        .hCount(hCount), .vCount(vCount), .rgb(rgb), .score(score),
        .q_I(q_I), .q_Game(q_Game), .q_Done(q_Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [9:0] h, input logic [9:0] v);
        hCount = h;
        vCount = v;
        #1;
    endtask

    initial begin
        rst = 1'b1; bright = 1'b1; up = 1'b0; hCount = '0; vCount = '0;
        step(2);
        rst = 1'b0;
        chk("rst_qI", 16'(q_I), 16'd1);
        chk("rst_qGame", 16'(q_Game), 16'd0);
        chk("rst_qDone", 16'(q_Done), 16'd0);
        chk("rst_score", score, 16'd0);
        step(3);
        chk("idle_hold", 16'(q_I), 16'd1);
        up = 1'b1; step(1); up = 1'b0;
        chk("start_game", 16'(q_Game), 16'd1);
        px(780, 380); chk("block_780", 16'(rgb), 16'h000);
        px(779, 380); chk("sky_779", 16'(rgb), 16'hFFF);
        px(210, 380); chk("dino_game", 16'(rgb), 16'h0A0);
        bright = 1'b0; #1; chk("dark_game", 16'(rgb), 16'h000); bright = 1'b1;
        px(600, 401); chk("ground", 16'(rgb), 16'h888);
        step(137);
        px(247, 380); chk("block_232_edge", 16'(rgb), 16'h000);
        px(248, 380); chk("block_232_past", 16'(rgb), 16'hFFF);
        chk("game_at_232", 16'(q_Game), 16'd1);
        step(1);
        px(243, 380); chk("block_228", 16'(rgb), 16'h000);
        chk("game_at_228", 16'(q_Game), 16'd1);
        step(1);
        chk("collide_done", 16'(q_Done), 16'd1);
        chk("collide_score", score, 16'd0);
        step(3);
        chk("done_hold", 16'(q_Done), 16'd1);
        px(243, 380); chk("frozen_block", 16'(rgb), 16'h000);
        px(244, 380); chk("frozen_sky", 16'(rgb), 16'hFFF);
        px(210, 380); chk("dino_done", 16'(rgb), 16'hF00);
        bright = 1'b0; #1; chk("dark_done", 16'(rgb), 16'h000); bright = 1'b1;
        up = 1'b1; step(1); up = 1'b0;
        chk("restart_game", 16'(q_Game), 16'd1);
        chk("restart_score", score, 16'd0);
        px(780, 380); chk("restart_bx", 16'(rgb), 16'h000);
        for (int i = 0; i < 5; i++) begin
            up = 1'b1; step(1); up = 1'b0; step(1);
        end
        chk("pulses_game", 16'(q_Game), 16'd1);
        rst = 1'b1; #1;
        chk("async_rst_qI", 16'(q_I), 16'd1);
        chk("async_rst_score", score, 16'd0);
        rst = 1'b0;
        step(2);
        chk("post_rst_idle", 16'(q_I), 16'd1);
        px(780, 380); chk("post_rst_bx", 16'(rgb), 16'h000);
        up = 1'b1; step(1); up = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(123);
            px(303, 380); chk("block_288", 16'(rgb), 16'h000);
            up = 1'b1; step(1); up = 1'b0;
            if (k == 0) begin
                step(16);
                px(210, 320); chk("dino_peak", 16'(rgb), 16'h0A0);
                px(210, 380); chk("dino_left_ground", 16'(rgb), 16'hFFF);
                step(20);
            end else begin
                step(36);
            end
            chk("score_before", score, 16'(k));
            px(155, 380); chk("block_140", 16'(rgb), 16'h000);
            step(1);
            chk("score_after", score, 16'(k + 1));
            px(780, 380); chk("reload_780", 16'(rgb), 16'h000);
            chk("win_state", 16'(q_Done), (k == 9) ? 16'd1 : 16'd0);
        end
        px(210, 380); chk("win_dino_red", 16'(rgb), 16'hF00);
        step(5);
        chk("win_hold", 16'(q_Done), 16'd1);
        chk("win_score_hold", score, 16'd10);
        up = 1'b1; step(1);
        for (int i = 0; i < 5000 && !q_Done; i++) begin
            up = (i % 2 == 0); step(1);
        end
        up = 1'b0;
        chk("toggle_done", 16'(q_Done), 16'd1);
        chk("toggle_score_le", 16'(score <= 16'd10), 16'd1);
        step(10);
        chk("toggle_done_hold", 16'(q_Done), 16'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
